posit_mul_pipe: RTL and testbench
=================================

Name: posit_mul_pipe

Overview:
- Two-stage, valid/ready pipelined multiplier for decoded posit operands.
- Sits directly downstream of a pair of posit decoders, one per operand. Consumes sign, signed combined regime/exponent and normalized mantissa with implicit bit.
- Produces a normalized product: sign, exponent, double-width mantissa, plus zero/NaR flags. Output feeds the alignment/accumulate stage of the dot-product unit.
- Throughput 1 product/cycle; latency 2 cycles.

Parameters:
- n, 16, posit word size.
- es, 1, exponent field size.
- nd, pdpu_pkg::clog2(n-1), derived; do not override.
- EXP_WIDTH, nd+es, decoder exponent magnitude width; input exponent is EXP_WIDTH+1 bits signed.
- MANT_WIDTH, n-es-3, decoder fraction width; input mantissa is MANT_WIDTH+1 bits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  pipeline can accept the operand pair.
- a_sign_i  in  1  sign of operand A.
- a_exp_i  in  EXP_WIDTH+1 (signed)  regime/exponent of operand A.
- a_mant_i  in  MANT_WIDTH+1  mantissa of operand A; MSB is the implicit bit.
- b_sign_i, b_exp_i, b_mant_i  in  same widths  operand B.
- out_valid_o  out  1  product valid.
- out_ready_i  in  1  downstream accepts product.
- out_sign_o  out  1  product sign.
- out_exp_o  out  EXP_WIDTH+2 (signed)  product exponent.
- out_mant_o  out  2*MANT_WIDTH+2  normalized product mantissa; MSB=1 unless zero or NaR.
- out_zero_o  out  1  product is zero.
- out_nar_o  out  1  product is NaR.

Behaviour:
- Special-value classification per operand, combinational at input:
  - zero = implicit bit 0 and sign 0.
  - NaR = implicit bit 0 and sign 1.
- Stage 1 register (s1), loaded on input handshake:
  - sign = a_sign^b_sign.
  - exp_sum = sext(a_exp)+sext(b_exp), EXP_WIDTH+2 bits.
  - prod = a_mant*b_mant, unsigned, 2*MANT_WIDTH+2 bits.
  - nar = a_nar|b_nar.
  - zero = (a_zero|b_zero) & ~nar.
- Stage 2 register (s2), loaded from s1:
  - If prod MSB=1: exp=exp_sum+1, mant=prod.
  - Otherwise: exp=exp_sum, mant=prod<<1 with zero fill.
  - If nar: sign=1, exp=0, mant=0.
  - If zero: sign=0, exp=0, mant=0.
  - NaR has priority over zero, so NaR*0 = NaR.
- Outputs are driven directly from s2 registers; no combinational path from operand inputs to outputs.
- Handshake:
  - s2_en = ~s2_valid | out_ready_i.
  - s1_en = ~s1_valid | s2_en.
  - in_ready_o = s1_en.
  - Input transfer occurs when in_valid_i & in_ready_o.
  - s1_valid <= in_valid_i when s1_en.
  - s2_valid <= s1_valid when s2_en.
  - Data registers load only when their stage enable is high and the upstream valid is high (clock-enable, no bubbles written over held data).
  - in_ready_o depends combinationally on out_ready_i. This is accepted; no skid buffer.
- Backpressure: while out_valid_o=1 and out_ready_i=0, all out_* remain stable. s1 fills at most one more item, then in_ready_o=0.
- Simultaneous events: a full pipeline with out_ready_i=1 and in_valid_i=1 shifts every stage in the same cycle; no bubble, no loss.
- Reset, asynchronous, any time including mid-operation:
  - s1_valid=0, s2_valid=0, all data registers 0.
  - Outputs: out_valid_o=0, out_sign_o=0, out_exp_o=0, out_mant_o=0, out_zero_o=0, out_nar_o=0.
  - in_ready_o=1 after reset.
  - In-flight items are discarded.
- Exponent width proof for n=16, es=1: inputs lie in [-30,29], so the product lies in [-60,59], which fits 7 bits signed. The general case holds by the same bound; no saturation logic.

Decomposition:
- pdpu_pkg:
  - clog2 (existing).
  - Width helper functions for EXP_WIDTH and MANT_WIDTH, shared with the decoder.
  - A packed struct type for a decoded operand {sign, exp, mant}, parameterized by width constants.
- Sub-module pipe_stage: one-entry valid/ready register slice with parameterized payload width and async active-high reset. Instantiated twice (s1, s2).
- Classification and normalization remain inline combinational logic.

Test Plan:
All scenarios use n=16, es=1, giving 13-bit input mantissa and 26-bit output mantissa.
- 1.0*1.0: both exp=0, mant=0x1000, signs 0 -> after 2 cycles: sign 0, exp 0, mant 0x2000000, zero 0, nar 0.
- 1.5*(-1.5): mant 0x1800 each, b_sign=1 -> sign 1, exp 1, mant 0x2400000.
- Exponent extremes: a_exp=29, b_exp=29, mant 0x1FFF each -> exp 59, mant 0x3FFC001. Also a_exp=-30, b_exp=-30, mant 0x1000 -> exp -60, mant 0x2000000.
- Specials: zero*3.0 -> zero=1, mant=0, sign=0. NaR*zero -> nar=1, zero=0, sign=1.
- Backpressure: stream 4 back-to-back items with out_ready_i low for cycles 3-6. in_ready_o must drop after 2 items are held, outputs stay stable, all 4 products emerge in order with none dropped or duplicated.
- Reset mid-stream: assert rst_i with both stages valid -> out_valid_o=0 immediately (async), all outputs 0, in_ready_o=1. After release, the first new item appears 2 cycles after acceptance.

Source files
------------

// File: rtl/pdpu_pkg.sv
// Shared helpers for the posit dot-product unit: width functions and the
// decoded-operand record used between the decoders and the multiplier.
package pdpu_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

    function automatic int exp_width(input int n, input int es);
        return clog2(n - 1) + es;
    endfunction

    function automatic int mant_width(input int n, input int es);
        return n - es - 3;
    endfunction

    localparam int N_DEF      = 16;
    localparam int ES_DEF     = 1;
    localparam int EXP_W_DEF  = exp_width(N_DEF, ES_DEF);
    localparam int MANT_W_DEF = mant_width(N_DEF, ES_DEF);

    // Decoder output for one operand; mant MSB is the implicit bit.
    typedef struct packed {
        logic                       sign;
        logic signed [EXP_W_DEF:0]  exp;
        logic [MANT_W_DEF:0]        mant;
    } operand_t;

endpackage

// File: rtl/posit_mul_pipe_if.sv
// Operand/product handshake bundle between the decoders, the multiplier and
// the alignment stage.
interface posit_mul_pipe_if #(
    parameter int n  = 16,
    parameter int es = 1
);
    import pdpu_pkg::*;

    localparam int EXP_WIDTH  = exp_width(n, es);
    localparam int MANT_WIDTH = mant_width(n, es);

    logic                          in_valid_i;
    logic                          in_ready_o;
    logic                          a_sign_i;
    logic signed [EXP_WIDTH:0]     a_exp_i;
    logic [MANT_WIDTH:0]           a_mant_i;
    logic                          b_sign_i;
    logic signed [EXP_WIDTH:0]     b_exp_i;
    logic [MANT_WIDTH:0]           b_mant_i;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic                          out_sign_o;
    logic signed [EXP_WIDTH+1:0]   out_exp_o;
    logic [2*MANT_WIDTH+1:0]       out_mant_o;
    logic                          out_zero_o;
    logic                          out_nar_o;

    modport slave (
        input  in_valid_i, a_sign_i, a_exp_i, a_mant_i,
               b_sign_i, b_exp_i, b_mant_i, out_ready_i,
        output in_ready_o, out_valid_o, out_sign_o, out_exp_o,
               out_mant_o, out_zero_o, out_nar_o
    );

    modport master (
        output in_valid_i, a_sign_i, a_exp_i, a_mant_i,
               b_sign_i, b_exp_i, b_mant_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_sign_o, out_exp_o,
               out_mant_o, out_zero_o, out_nar_o
    );

endinterface

// File: rtl/posit_mul_pipe_stage.sv
// One-entry valid/ready register slice. The enable comes from the parent so
// that both slices share one ready chain.
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
        end
    end

    // Payload only moves with a real item, so a bubble never overwrites it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (en_i && valid_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/posit_mul_pipe.sv
// Two-stage pipelined multiplier for decoded posit operands: stage 1 forms
// sign/exponent sum/raw product, stage 2 normalizes and applies zero/NaR.
module posit_mul_pipe
    import pdpu_pkg::*;
#(
    parameter int n  = 16,
    parameter int es = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    posit_mul_pipe_if.slave   bus
);

    localparam int nd         = clog2(n - 1);
    localparam int EXP_WIDTH  = nd + es;
    localparam int MANT_WIDTH = mant_width(n, es);
    localparam int EW2        = EXP_WIDTH + 2;
    localparam int PW         = 2 * MANT_WIDTH + 2;
    localparam int SW         = 1 + EW2 + PW + 2;

    typedef struct packed {
        logic           sign;
        logic [EW2-1:0] exp;
        logic [PW-1:0]  prod;
        logic           nar;
        logic           zero;
    } s1_t;

    typedef struct packed {
        logic           sign;
        logic [EW2-1:0] exp;
        logic [PW-1:0]  mant;
        logic           zero;
        logic           nar;
    } s2_t;

    logic a_zero, a_nar, b_zero, b_nar;
    logic s1_en, s2_en;
    logic s1_valid, s2_valid;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;

    // A clear implicit bit marks a special; the sign picks zero vs NaR.
    assign a_zero = ~bus.a_mant_i[MANT_WIDTH] & ~bus.a_sign_i;
    assign a_nar  = ~bus.a_mant_i[MANT_WIDTH] &  bus.a_sign_i;
    assign b_zero = ~bus.b_mant_i[MANT_WIDTH] & ~bus.b_sign_i;
    assign b_nar  = ~bus.b_mant_i[MANT_WIDTH] &  bus.b_sign_i;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = bus.a_sign_i ^ bus.b_sign_i;
        s1_d.exp  = {bus.a_exp_i[EXP_WIDTH], bus.a_exp_i}
                  + {bus.b_exp_i[EXP_WIDTH], bus.b_exp_i};
        s1_d.prod = {{(MANT_WIDTH+1){1'b0}}, bus.a_mant_i}
                  * {{(MANT_WIDTH+1){1'b0}}, bus.b_mant_i};
        s1_d.nar  = a_nar | b_nar;
        s1_d.zero = (a_zero | b_zero) & ~(a_nar | b_nar);
    end

    assign s2_en          = ~s2_valid | bus.out_ready_i;
    assign s1_en          = ~s1_valid | s2_en;
    assign bus.in_ready_o = s1_en;

    pipe_stage #(.WIDTH(SW)) u_s1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (s1_en),
        .valid_i (bus.in_valid_i),
        .data_i  (s1_d),
        .valid_o (s1_valid),
        .data_o  (s1_q)
    );

    // Product of two [1,2) mantissas lies in [1,4): at most one left shift.
    always_comb begin
        s2_d = '0;
        if (s1_q.nar) begin
            s2_d.sign = 1'b1;
            s2_d.nar  = 1'b1;
        end else if (s1_q.zero) begin
            s2_d.zero = 1'b1;
        end else if (s1_q.prod[PW-1]) begin
            s2_d.sign = s1_q.sign;
            s2_d.exp  = s1_q.exp + {{(EW2-1){1'b0}}, 1'b1};
            s2_d.mant = s1_q.prod;
        end else begin
            s2_d.sign = s1_q.sign;
            s2_d.exp  = s1_q.exp;
            s2_d.mant = {s1_q.prod[PW-2:0], 1'b0};
        end
    end

    pipe_stage #(.WIDTH(SW)) u_s2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (s2_en),
        .valid_i (s1_valid),
        .data_i  (s2_d),
        .valid_o (s2_valid),
        .data_o  (s2_q)
    );

    assign bus.out_valid_o = s2_valid;
    assign bus.out_sign_o  = s2_q.sign;
    assign bus.out_exp_o   = s2_q.exp;
    assign bus.out_mant_o  = s2_q.mant;
    assign bus.out_zero_o  = s2_q.zero;
    assign bus.out_nar_o   = s2_q.nar;

endmodule

// File: tb/tb_posit_mul_pipe.sv
// Bench for posit_mul_pipe (n=16, es=1): directed values, random streams
// against a value-level product model, backpressure and mid-stream reset.
module tb_posit_mul_pipe;
    import pdpu_pkg::*;

    localparam int MW = MANT_W_DEF;

    typedef struct {
        logic   sign;
        int     exp;
        longint mant;
        logic   zero;
        logic   nar;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass   = 0;
    int   n_checks = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    posit_mul_pipe_if #(.n(16), .es(1)) bus ();

    posit_mul_pipe #(.n(16), .es(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic operand_t mk(input logic s, input int e, input int m);
        operand_t o;
        o.sign = s;
        o.exp  = 6'(e);
        o.mant = 13'(m);
        return o;
    endfunction

    function automatic res_t mkres(input logic s, input int e, input longint m,
                                   input logic z, input logic nr);
        res_t r;
        r.sign = s; r.exp = e; r.mant = m; r.zero = z; r.nar = nr;
        return r;
    endfunction

    function automatic operand_t rand_operand();
        int e;
        e = int'($urandom_range(0, 59)) - 30;
        if ($urandom_range(0, 7) == 0)
            return mk(1'($urandom), e, int'($urandom_range(0, 4095)));
        return mk(1'($urandom), e, 4096 + int'($urandom_range(0, 4095)));
    endfunction

    // Value-level model: product = 2^(ea+eb) * ma*mb / 2^(2*MW), renormalized
    // so the leading one sits at the top of the double-width mantissa.
    function automatic res_t model(input operand_t a, input operand_t b);
        res_t   r;
        longint prod;
        int     p;
        logic   a_spec, b_spec, nar, zero;
        a_spec = !a.mant[MW];
        b_spec = !b.mant[MW];
        nar    = (a_spec && a.sign) || (b_spec && b.sign);
        zero   = !nar && ((a_spec && !a.sign) || (b_spec && !b.sign));
        r = mkres(1'b0, 0, 0, 1'b0, 1'b0);
        if (nar) begin
            r.sign = 1'b1;
            r.nar  = 1'b1;
        end else if (zero) begin
            r.zero = 1'b1;
        end else begin
            prod = longint'(a.mant) * longint'(b.mant);
            p = 0;
            for (int i = 0; i < 64; i++) if (prod[i]) p = i;
            r.sign = a.sign ^ b.sign;
            r.exp  = int'(a.exp) + int'(b.exp) + p - 2 * MW;
            r.mant = prod << (2 * MW + 1 - p);
        end
        return r;
    endfunction

    task automatic drive(input operand_t a, input operand_t b);
        bus.a_sign_i = a.sign;
        bus.a_exp_i  = a.exp;
        bus.a_mant_i = a.mant;
        bus.b_sign_i = b.sign;
        bus.b_exp_i  = b.exp;
        bus.b_mant_i = b.mant;
    endtask

    task automatic check_out(input string tag, input res_t r);
        chk({tag, "_sign"}, 64'(bus.out_sign_o), 64'(r.sign));
        chk({tag, "_exp"},  64'(bus.out_exp_o),  64'(r.exp));
        chk({tag, "_mant"}, 64'(bus.out_mant_o), 64'(r.mant));
        chk({tag, "_zero"}, 64'(bus.out_zero_o), 64'(r.zero));
        chk({tag, "_nar"},  64'(bus.out_nar_o),  64'(r.nar));
    endtask

    // Called just after a rising edge with an empty pipe and out_ready high.
    task automatic directed(input string tag, input operand_t a, input operand_t b,
                            input res_t r);
        bus.in_valid_i = 1'b1;
        drive(a, b);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'd1);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        drive(rand_operand(), rand_operand());
        @(negedge clk);
        chk({tag, "_lat1_valid"}, 64'(bus.out_valid_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_lat2_valid"}, 64'(bus.out_valid_o), 64'd1);
        check_out(tag, r);
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input string tag, input int n_items, input bit bp_mode);
        operand_t qa[$];
        operand_t qb[$];
        res_t     r;
        int       sent = 0;
        int       got  = 0;
        int       cyc  = 0;
        bit       stall_prev = 1'b0;
        bit       seen_block = 1'b0;
        logic [36:0] snap = '0;
        logic [36:0] cur;
        for (int i = 0; i < n_items; i++) begin
            qa.push_back(rand_operand());
            qb.push_back(rand_operand());
        end
        while (got < n_items && cyc < 4000) begin
            cyc++;
            bus.out_ready_i = bp_mode ? !(cyc >= 3 && cyc <= 6) : ($urandom_range(0, 3) != 0);
            if (sent < n_items) begin
                bus.in_valid_i = bp_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
                drive(qa[sent], qb[sent]);
            end else begin
                bus.in_valid_i = 1'b0;
                drive(rand_operand(), rand_operand());
            end
            @(negedge clk);
            cur = {bus.out_valid_o, bus.out_sign_o, bus.out_exp_o, bus.out_mant_o,
                   bus.out_zero_o, bus.out_nar_o};
            chk({tag, "_in_ready"}, 64'(bus.in_ready_o),
                64'(!(sb.size() == 2 && !bus.out_ready_i)));
            if (stall_prev) chk({tag, "_hold"}, 64'(cur), 64'(snap));
            if (!bus.in_ready_o) seen_block = 1'b1;
            if (bus.out_valid_o && bus.out_ready_i) begin
                chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    r = sb.pop_front();
                    check_out(tag, r);
                end
                got++;
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                sb.push_back(model(qa[sent], qb[sent]));
                sent++;
            end
            stall_prev = bus.out_valid_o && !bus.out_ready_i;
            snap = cur;
            @(posedge clk); #1;
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        chk({tag, "_drained"}, 64'(got), 64'(n_items));
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        if (bp_mode) chk({tag, "_stall_seen"}, 64'(seen_block), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        drive(mk(0, 0, 0), mk(0, 0, 0));
        #3;
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_sign",      64'(bus.out_sign_o),  64'd0);
        chk("rst_exp",       64'(bus.out_exp_o),   64'd0);
        chk("rst_mant",      64'(bus.out_mant_o),  64'd0);
        chk("rst_zero",      64'(bus.out_zero_o),  64'd0);
        chk("rst_nar",       64'(bus.out_nar_o),   64'd0);
        chk("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        directed("one_x_one", mk(0, 0, 'h1000), mk(0, 0, 'h1000),
                 mkres(0, 0, 'h2000000, 0, 0));
        directed("p15_x_m15", mk(0, 0, 'h1800), mk(1, 0, 'h1800),
                 mkres(1, 1, 'h2400000, 0, 0));
        directed("exp_max", mk(0, 29, 'h1FFF), mk(0, 29, 'h1FFF),
                 mkres(0, 59, 'h3FFC001, 0, 0));
        directed("exp_min", mk(0, -30, 'h1000), mk(0, -30, 'h1000),
                 mkres(0, -60, 'h2000000, 0, 0));
        directed("zero_x_3", mk(0, 0, 0), mk(0, 1, 'h1800),
                 mkres(0, 0, 0, 1, 0));
        directed("nar_x_zero", mk(1, 0, 0), mk(0, 0, 0),
                 mkres(1, 0, 0, 0, 1));

        run_stream("bp", 4, 1'b1);
        run_stream("rnd", 300, 1'b0);

        // Fill both stages, then reset asynchronously between clock edges.
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        drive(rand_operand(), rand_operand());
        @(posedge clk); #1;
        drive(rand_operand(), rand_operand());
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        chk("pre_rst_full_valid", 64'(bus.out_valid_o), 64'd1);
        chk("pre_rst_in_ready",   64'(bus.in_ready_o),  64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("mid_rst_outputs",
            64'({bus.out_sign_o, bus.out_exp_o, bus.out_mant_o, bus.out_zero_o, bus.out_nar_o}),
            64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        chk("post_rst_no_stale", 64'(bus.out_valid_o), 64'd0);
        directed("post_rst", mk(0, 0, 'h1000), mk(0, 0, 'h1000),
                 mkres(0, 0, 'h2000000, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
